// File: rtl/result_frame_scanout.sv
// Captures one binary (majority-of-MSBs) frame into a 1-bit-per-pixel RAM and
// replays it in raster order over a valid/ready stream.
`timescale 1ns/1ps
module result_frame_scanout #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
) (
  input  logic                   clock,
  input  logic                   not_reset,
  input  logic [WIDTH_BITS-1:0]  iX,
  input  logic [HEIGHT_BITS-1:0] iY,
  input  logic [2:0]             iR,
  input  logic [2:0]             iG,
  input  logic [2:0]             iB,
  input  logic                   iWren,
  input  logic                   iStart,
  output logic                   oFrameReady,
  output logic                   oDropped,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [WIDTH_BITS-1:0]  oX,
  output logic [HEIGHT_BITS-1:0] oY,
  output logic [2:0]             oR,
  output logic [2:0]             oG,
  output logic [2:0]             oB,
  output logic                   oLast
);

  localparam int AW    = WIDTH_BITS + HEIGHT_BITS;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [CW-1:0] FRAME_PIXELS = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    READY   = 2'd1,
    FETCH   = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [WIDTH_BITS-1:0]  scan_x_q, scan_x_d;
  logic [HEIGHT_BITS-1:0] scan_y_q, scan_y_d;
  logic                   dropped_q, dropped_d;
  logic                   rd_bit_q;
  logic                   mem_we;
  logic                   wr_bit;
  logic                   last_pix;
  logic                   unused_lsbs;

  logic pix_mem [0:DEPTH-1];

  // Only the colour MSBs take part in the vote.
  assign wr_bit      = (iR[2] & iG[2]) | (iR[2] & iB[2]) | (iG[2] & iB[2]);
  assign unused_lsbs = ^{iR[1:0], iG[1:0], iB[1:0]};
  assign last_pix    = (&scan_x_q) & (&scan_y_q);

  always_ff @(posedge clock) begin
    if (mem_we) begin
      pix_mem[{iY, iX}] <= wr_bit;
    end
  end

  // Read port is enabled only in FETCH so the pixel stays put while stalled.
  always_ff @(posedge clock) begin
    if (state_q == FETCH) begin
      rd_bit_q <= pix_mem[{scan_y_q, scan_x_q}];
    end
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_q   <= COLLECT;
      count_q   <= '0;
      scan_x_q  <= '0;
      scan_y_q  <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      scan_x_q  <= scan_x_d;
      scan_y_q  <= scan_y_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    scan_x_d  = scan_x_q;
    scan_y_d  = scan_y_q;
    mem_we    = 1'b0;
    dropped_d = iWren && (state_q != COLLECT);
    case (state_q)
      COLLECT: begin
        if (iWren) begin
          mem_we  = 1'b1;
          count_d = count_q + CW'(1);
          // Strobes are counted, not unique addresses.
          if (count_q + CW'(1) == FRAME_PIXELS) begin
            state_d = READY;
          end
        end
      end
      READY: begin
        if (iStart) begin
          state_d  = FETCH;
          scan_x_d = '0;
          scan_y_d = '0;
        end
      end
      FETCH: begin
        state_d = PRESENT;
      end
      PRESENT: begin
        if (iReady) begin
          if (last_pix) begin
            state_d  = COLLECT;
            count_d  = '0;
            scan_x_d = '0;
            scan_y_d = '0;
          end else begin
            state_d = FETCH;
            if (&scan_x_q) begin
              scan_x_d = '0;
              scan_y_d = scan_y_q + HEIGHT_BITS'(1);
            end else begin
              scan_x_d = scan_x_q + WIDTH_BITS'(1);
            end
          end
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  assign oFrameReady = (state_q == READY);
  assign oDropped    = dropped_q;
  assign oValid      = (state_q == PRESENT);
  assign oX          = scan_x_q;
  assign oY          = scan_y_q;
  // The RAM read register is not reset, so colour is masked outside PRESENT.
  assign oR          = {3{rd_bit_q & oValid}};
  assign oG          = {3{rd_bit_q & oValid}};
  assign oB          = {3{rd_bit_q & oValid}};
  assign oLast       = oValid & last_pix;

endmodule

// File: tb/tb_result_frame_scanout.sv
// Scoreboard bench for result_frame_scanout on a 4x4 frame: stimulus pushes
// expected beats, a negedge monitor pops them on every accepted handshake.
`timescale 1ns/1ps
module tb_result_frame_scanout;

  localparam int WB   = 2;
  localparam int HB   = 2;
  localparam int W    = 1 << WB;
  localparam int H    = 1 << HB;
  localparam int NPIX = W * H;

  logic          clock = 1'b0;
  logic          not_reset = 1'b0;
  logic [WB-1:0] iX = '0;
  logic [HB-1:0] iY = '0;
  logic [2:0]    iR = '0, iG = '0, iB = '0;
  logic          iWren = 1'b0;
  logic          iStart = 1'b0;
  logic          iReady = 1'b1;
  logic          oFrameReady, oDropped, oValid, oLast;
  logic [WB-1:0] oX;
  logic [HB-1:0] oY;
  logic [2:0]    oR, oG, oB;

  typedef struct {
    int x;
    int y;
    int bitv;
    int last;
  } beat_t;

  beat_t sb[$];
  int    frame_model[NPIX];
  int    total_cnt  = 0;
  int    pass_cnt   = 0;
  int    beats_seen = 0;
  bit    rand_ready = 1'b0;

  result_frame_scanout #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) dut (
    .clock(clock), .not_reset(not_reset),
    .iX(iX), .iY(iY), .iR(iR), .iG(iG), .iB(iB),
    .iWren(iWren), .iStart(iStart),
    .oFrameReady(oFrameReady), .oDropped(oDropped), .oValid(oValid),
    .iReady(iReady), .oX(oX), .oY(oY), .oR(oR), .oG(oG), .oB(oB), .oLast(oLast)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int majority(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
    int votes;
    votes = int'(r[2]) + int'(g[2]) + int'(b[2]);
    return (votes >= 2) ? 1 : 0;
  endfunction

  // Caller is always at posedge+1; returns at posedge+1 after the capturing edge.
  task automatic write_px(input int x, input int y, input logic [2:0] r,
                          input logic [2:0] g, input logic [2:0] b, input bit upd);
    iX = WB'(x); iY = HB'(y); iR = r; iG = g; iB = b; iWren = 1'b1;
    if (upd) frame_model[y * W + x] = majority(r, g, b);
    @(posedge clock); #1;
    iWren = 1'b0;
  endtask

  task automatic queue_frame();
    beat_t bt;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        bt.x    = x;
        bt.y    = y;
        bt.bitv = frame_model[y * W + x];
        bt.last = (x == W - 1 && y == H - 1) ? 1 : 0;
        sb.push_back(bt);
      end
    end
  endtask

  task automatic pulse_start();
    iStart = 1'b1;
    @(posedge clock); #1;
    iStart = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_remaining", sb.size(), 0);
  endtask

  task automatic write_random_raster();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        write_px(x, y, 3'($urandom), 3'($urandom), 3'($urandom), 1'b1);
  endtask

  // Ready driver: either tied high or randomly stalling.
  initial forever begin
    @(posedge clock); #1;
    iReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops on handshake, checks hold-stability across stalls.
  initial begin
    bit    prev_stall = 1'b0;
    beat_t held;
    beat_t got;
    beat_t exp;
    forever begin
      @(negedge clock);
      if (!not_reset) begin
        prev_stall = 1'b0;
      end else begin
        got.x = int'(oX); got.y = int'(oY); got.bitv = int'(oR[0]); got.last = int'(oLast);
        if (prev_stall) begin
          check("stall_valid_held", int'(oValid), 1);
          check("stall_x_held", got.x, held.x);
          check("stall_y_held", got.y, held.y);
          check("stall_r_held", int'(oR), held.bitv * 7);
        end
        prev_stall = oValid && !iReady;
        held = got;
        held.bitv = int'(oR[0]);
        if (oValid && iReady) begin
          if (sb.size() == 0) begin
            check("unexpected_beat_at_xy", got.y * W + got.x, -1);
          end else begin
            exp = sb.pop_front();
            beats_seen++;
            check("beat_x", got.x, exp.x);
            check("beat_y", got.y, exp.y);
            check("beat_r", int'(oR), exp.bitv * 7);
            check("beat_g", int'(oG), exp.bitv * 7);
            check("beat_b", int'(oB), exp.bitv * 7);
            check("beat_last", got.last, exp.last);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int start_beats;

    // Reset state
    cycles(2);
    check("rst_valid", int'(oValid), 0);
    check("rst_frame_ready", int'(oFrameReady), 0);
    check("rst_dropped", int'(oDropped), 0);
    check("rst_x", int'(oX), 0);
    check("rst_y", int'(oY), 0);
    check("rst_rgb", int'({oR, oG, oB}), 0);
    check("rst_last", int'(oLast), 0);
    not_reset = 1'b1;
    cycles(1);

    // Frame 1: diagonal pattern, ready tied high
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        write_px(x, y, (x == y) ? 3'd7 : 3'd0, (x == y) ? 3'd7 : 3'd0,
                 (x == y) ? 3'd7 : 3'd0, 1'b1);
        if (x == W - 2 && y == H - 1) check("f1_not_ready_at_15", int'(oFrameReady), 0);
      end
    check("f1_ready_after_16", int'(oFrameReady), 1);
    check("f1_no_valid_in_ready", int'(oValid), 0);
    queue_frame();
    pulse_start();
    drain(200);
    cycles(2);
    check("f1_frame_ready_after_scan", int'(oFrameReady), 0);
    check("f1_valid_after_scan", int'(oValid), 0);

    // Majority spot checks plus random addresses with repeats
    write_px(0, 0, 3'd4, 3'd4, 3'd0, 1'b1);
    write_px(1, 0, 3'd4, 3'd0, 3'd0, 1'b1);
    for (int i = 2; i < NPIX - 1; i++)
      write_px($urandom_range(0, W - 1), $urandom_range(0, H - 1),
               3'($urandom), 3'($urandom), 3'($urandom), 1'b1);
    pulse_start();
    cycles(3);
    check("start_in_collect_valid", int'(oValid), 0);
    check("start_in_collect_ready", int'(oFrameReady), 0);
    write_px($urandom_range(0, W - 1), $urandom_range(0, H - 1),
             3'($urandom), 3'($urandom), 3'($urandom), 1'b1);
    check("f2_ready_after_16", int'(oFrameReady), 1);
    queue_frame();
    rand_ready = 1'b1;
    pulse_start();
    n = 0;
    while (!oValid && n < 20) begin cycles(1); n++; end
    check("f2_valid_seen", int'(oValid), 1);
    write_px(0, 0, 3'd7, 3'd7, 3'd7, 1'b0);
    check("drop_pulse", int'(oDropped), 1);
    cycles(1);
    check("drop_pulse_end", int'(oDropped), 0);
    drain(400);

    // iStart held high across collection: scan starts only once per frame
    cycles(2);
    iStart = 1'b1;
    write_random_raster();
    queue_frame();
    drain(400);
    cycles(6);
    check("held_start_no_rescan", int'(oValid), 0);
    check("held_start_not_ready", int'(oFrameReady), 0);
    iStart = 1'b0;

    // Reset mid-scan after five pixels
    write_random_raster();
    queue_frame();
    pulse_start();
    start_beats = beats_seen;
    n = 0;
    while (beats_seen - start_beats < 5 && n < 200) begin cycles(1); n++; end
    check("mid_scan_beats", beats_seen - start_beats, 5);
    #2;
    not_reset = 1'b0;
    #1;
    check("async_reset_valid", int'(oValid), 0);
    check("async_reset_ready", int'(oFrameReady), 0);
    sb.delete();
    @(posedge clock); #1;
    not_reset = 1'b1;
    cycles(1);
    write_random_raster();
    check("post_reset_ready", int'(oFrameReady), 1);
    queue_frame();
    pulse_start();
    drain(400);
    rand_ready = 1'b0;
    cycles(3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
